// File: rtl/async_rd_stream_port.sv
// Read-domain consumer end of an async FIFO: owns the read pointer, synchronises the
// write pointer, issues 1-cycle-latency RAM reads and presents entries as a first-word
// fall-through valid/ready stream through a 2-entry output buffer.
// Define ASYNC_RD_SYNC3_EN for a 3-flop write-pointer synchroniser (default: 2 flops).
module async_rd_stream_port #(
    parameter int unsigned ADDR_SIZE     = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_rstn,
    input  logic [ADDR_SIZE:0]    wr_addr_gray,
    output logic [ADDR_SIZE:0]    rd_addr_gray,
    output logic                  mem_rd_en,
    output logic [ADDR_SIZE-1:0]  mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [ADDR_SIZE:0]    rd_level,
    output logic                  almost_empty
);

    localparam int unsigned PW = ADDR_SIZE + 1;
    localparam int unsigned SW = ADDR_SIZE + 2;

    logic [ADDR_SIZE:0] wr_gray_s;
    logic [ADDR_SIZE:0] wr_bin_s;
    logic [ADDR_SIZE:0] rd_bin;
    logic [ADDR_SIZE:0] rd_bin_nxt;
    logic               ptr_empty;
    logic               pop;
    logic               inflight;
    logic [2:0]         credit;
    logic [SW-1:0]      occupancy;

    logic [DATA_WIDTH-1:0] buf_mem [2];
    logic                  buf_head;
    logic                  buf_tail;
    logic [1:0]            buf_cnt;

`ifdef ASYNC_RD_SYNC3_EN
    logic [ADDR_SIZE:0] rsyn1, rsyn2, rsyn3;

    // Three-stage write-pointer synchroniser.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rsyn1 <= '0;
            rsyn2 <= '0;
            rsyn3 <= '0;
        end else begin
            rsyn1 <= wr_addr_gray;
            rsyn2 <= rsyn1;
            rsyn3 <= rsyn2;
        end
    end

    assign wr_gray_s = rsyn3;
`else
    logic [ADDR_SIZE:0] rsyn1, rsyn2;

    // Two-stage write-pointer synchroniser.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rsyn1 <= '0;
            rsyn2 <= '0;
        end else begin
            rsyn1 <= wr_addr_gray;
            rsyn2 <= rsyn1;
        end
    end

    assign wr_gray_s = rsyn2;
`endif

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wr_bin_s = '0;
        for (int i = 0; i < PW; i++) begin
            wr_bin_s[i] = ^(wr_gray_s >> i);
        end
    end

    assign ptr_empty = (rd_bin == wr_bin_s);
    assign rd_level  = wr_bin_s - rd_bin;
    assign pop       = m_valid && m_ready;

    // Credit: never issue a read that could find no buffer slot when its data lands.
    always_comb begin
        credit     = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        mem_rd_en  = !ptr_empty && (credit < 3'd2);
        rd_bin_nxt = rd_bin + PW'(1);
    end

    assign mem_rd_addr = rd_bin[ADDR_SIZE-1:0];

    // Read pointer, its Gray copy for the write domain, and the in-flight read flag.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_bin       <= '0;
            rd_addr_gray <= '0;
            inflight     <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            if (mem_rd_en) begin
                rd_bin       <= rd_bin_nxt;
                rd_addr_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
            end
        end
    end

    // Output buffer storage; returning RAM data is written at the tail.
    always_ff @(posedge rd_clk) begin
        if (inflight) begin
            buf_mem[buf_tail] <= mem_rd_data;
        end
    end

    // Output buffer pointers and count; push and pop together leave the count unchanged.
    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            buf_head <= 1'b0;
            buf_tail <= 1'b0;
            buf_cnt  <= 2'd0;
        end else begin
            if (inflight) buf_tail <= ~buf_tail;
            if (pop)      buf_head <= ~buf_head;
            buf_cnt <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // Stream outputs and almost-empty flag; occupancy counts RAM, buffer and in-flight entries.
    always_comb begin
        m_valid      = (buf_cnt != 2'd0);
        m_data       = buf_mem[buf_head];
        occupancy    = SW'(rd_level) + SW'(buf_cnt) + SW'(inflight);
        almost_empty = (occupancy <= SW'(AEMPTY_THRESH));
    end

endmodule

// File: tb/tb_async_rd_stream_port.sv
// Scoreboard bench for async_rd_stream_port: the bench plays the write domain and the
// FIFO RAM, queues each written word as the expected stream output, and a monitor pops
// and compares on every accepted beat.
module tb_async_rd_stream_port;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;

    logic          rd_clk;
    logic          rd_rstn;
    logic [AW:0]   wr_addr_gray;
    logic [AW:0]   rd_addr_gray;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic [AW:0]   rd_level;
    logic          almost_empty;

    logic [DW-1:0] ram [16];
    logic [AW:0]   wr_bin;
    logic [DW-1:0] exp_q [$];
    int            total;
    int            bad;
    int            rd_cnt;

    async_rd_stream_port #(
        .ADDR_SIZE    (AW),
        .DATA_WIDTH   (DW),
        .AEMPTY_THRESH(2)
    ) dut (
        .rd_clk      (rd_clk),
        .rd_rstn     (rd_rstn),
        .wr_addr_gray(wr_addr_gray),
        .rd_addr_gray(rd_addr_gray),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .rd_level    (rd_level),
        .almost_empty(almost_empty)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // RAM read port model: data one cycle after the strobe.
    always @(posedge rd_clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every beat that will be accepted at the next edge is checked in order.
    always @(negedge rd_clk) begin
        if (mem_rd_en) rd_cnt++;
        if (rd_rstn && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got %h expected none", m_data);
            end else begin
                check("stream_data", m_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge rd_clk);
        #2;
    endtask

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    // Write domain: store n words into the RAM and publish the new write pointer.
    task automatic write_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            ram[wr_bin[AW-1:0]] = base + DW'(i);
            exp_q.push_back(base + DW'(i));
            wr_bin = wr_bin + 5'd1;
        end
        wr_addr_gray = gray(wr_bin);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!m_valid && n < budget) begin
            @(negedge rd_clk);
            n++;
        end
        if (!m_valid) begin
            total++;
            bad++;
            $display("FAIL wait_valid: got timeout expected m_valid");
        end
    endtask

    task automatic drain(input int budget);
        int n;
        m_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge rd_clk);
            n++;
        end
        check("drain_done", 32'(exp_q.size()), 32'd0);
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] head;
        int            cnt;
        total        = 0;
        bad          = 0;
        rd_cnt       = 0;
        wr_bin       = '0;
        rd_rstn      = 1'b0;
        wr_addr_gray = '0;
        m_ready      = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = '0;

        // Reset state
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rd_gray", 32'(rd_addr_gray), 32'd0);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        check("rst_level", 32'(rd_level), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        tick();
        rd_rstn = 1'b1;
        tick();

        // Single word: valid appears after exactly four edges
        m_ready = 1'b1;
        write_n(1, 32'hA5A5_0001);
        repeat (3) @(posedge rd_clk);
        @(negedge rd_clk);
        check("lat_early", 32'(m_valid), 32'd0);
        @(posedge rd_clk);
        @(negedge rd_clk);
        check("lat_on", 32'(m_valid), 32'd1);
        check("single_data", m_data, 32'hA5A5_0001);
        drain(20);
        check("single_gray", 32'(rd_addr_gray), 32'd1);

        // Reset back to zero pointers for the full-depth burst
        rd_rstn = 1'b0;
        wr_bin = '0;
        wr_addr_gray = '0;
        tick();
        rd_rstn = 1'b1;
        tick();

        // Burst: 16 entries back to back
        m_ready = 1'b1;
        write_n(16, 32'hB000_0000);
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        check("burst_level16", 32'(rd_level), 32'd16);
        wait_valid(20);
        cnt = 0;
        while (m_valid && cnt < 40) begin
            cnt++;
            @(negedge rd_clk);
        end
        check("burst_consec", 32'(cnt), 32'd16);
        check("burst_level0", 32'(rd_level), 32'd0);
        check("burst_gray", 32'(rd_addr_gray), 32'b11000);
        check("burst_q", 32'(exp_q.size()), 32'd0);
        tick();
        m_ready = 1'b0;

        // Backpressure: only two reads issued while the sink stalls
        rd_cnt = 0;
        head = 32'hC000_0000;
        write_n(8, 32'hC000_0000);
        repeat (12) @(negedge rd_clk);
        check("bp_reads", 32'(rd_cnt), 32'd2);
        check("bp_level", 32'(rd_level), 32'd6);
        check("bp_valid", 32'(m_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold", m_data, head);
            @(negedge rd_clk);
        end
        tick();
        drain(40);

        // almost_empty: three entries -> deasserted; one pop -> asserted
        write_n(3, 32'hD000_0000);
        repeat (8) @(negedge rd_clk);
        check("ae_level", 32'(rd_level), 32'd1);
        check("ae_low", 32'(almost_empty), 32'd0);
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        @(negedge rd_clk);
        check("ae_high", 32'(almost_empty), 32'd1);
        tick();
        drain(20);

        // Wrap: advance pointers to 30, then write across the wrap point
        write_n(3, 32'hE000_0000);
        drain(20);
        check("wrap_gray30", 32'(rd_addr_gray), 32'(gray(5'd30)));
        write_n(4, 32'hF000_0000);
        repeat (10) @(negedge rd_clk);
        check("wrap_level", 32'(rd_level), 32'd2);
        check("wrap_gray0", 32'(rd_addr_gray), 32'd0);
        tick();
        drain(30);
        check("wrap_gray2", 32'(rd_addr_gray), 32'b00011);
        check("wrap_empty", 32'(rd_level), 32'd0);
        check("wrap_no_rd", 32'(mem_rd_en), 32'd0);

        // Reset mid-stream: outputs clear without waiting for a clock edge
        write_n(5, 32'h1111_0000);
        wait_valid(20);
        #2;
        rd_rstn = 1'b0;
        wr_bin = '0;
        wr_addr_gray = '0;
        exp_q.delete();
        #1;
        check("mrst_valid", 32'(m_valid), 32'd0);
        check("mrst_gray", 32'(rd_addr_gray), 32'd0);
        check("mrst_aempty", 32'(almost_empty), 32'd1);
        check("mrst_level", 32'(rd_level), 32'd0);
        tick();
        tick();
        rd_rstn = 1'b1;
        tick();

        // Recovery after reset
        write_n(1, 32'h2222_0001);
        wait_valid(20);
        check("post_rst_data", m_data, 32'h2222_0001);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
